// File: rtl/time_display_driver.sv
// time_display_driver: takes a packed time word from the clock counters,
// converts the two selected fields to BCD with a fixed-latency double-dabble
// converter, and scans the result onto a 4-digit common-anode 7-segment display.
module time_display_driver #(
  parameter int unsigned SCAN_DIV = 2
) (
  input  logic        kh_clk,
  input  logic        reset,
  input  logic [23:0] disp_time,
  input  logic        time_valid,
  input  logic        show_sec,
  input  logic        mode_12hr,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy,
  output logic        overrun
);

  // Digit codes held in the display registers: 0-9 are decimal digits.
  localparam logic [3:0] CODE_BLANK = 4'hA;
  localparam logic [3:0] CODE_DASH  = 4'hB;
  localparam logic [7:0] PRESCALE_LAST = 8'(SCAN_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

  state_t          state;
  logic [4:0]      lat_hr;
  logic [5:0]      lat_min;
  logic [5:0]      lat_sec;
  logic            lat_show_sec;
  logic            lat_mode_12hr;
  logic [5:0]      hi_bin;
  logic [5:0]      lo_bin;
  logic [7:0]      hi_bcd;
  logic [7:0]      lo_bcd;
  logic [2:0]      iter;
  logic            bad;
  logic            pm;
  logic [3:0][3:0] digits;
  logic            colon_lit;
  logic            pm_lit;
  logic [7:0]      prescaler;
  logic [1:0]      scan_idx;
  logic [5:0]      hr_map;
  logic [7:0]      hi_adj;
  logic [7:0]      lo_adj;
  logic            unused_frac;

  // The fractional seconds field is never displayed.
  assign unused_frac = ^disp_time[6:0];

  function automatic logic [7:0] dabble_adjust(input logic [7:0] bcd);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = bcd[7:4];
    units = bcd[3:0];
    if (tens >= 4'd5)  tens  = tens + 4'd3;
    if (units >= 4'd5) units = units + 4'd3;
    return {tens, units};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] pattern;
    case (code)
      4'd0:      pattern = 7'h40;
      4'd1:      pattern = 7'h79;
      4'd2:      pattern = 7'h24;
      4'd3:      pattern = 7'h30;
      4'd4:      pattern = 7'h19;
      4'd5:      pattern = 7'h12;
      4'd6:      pattern = 7'h02;
      4'd7:      pattern = 7'h78;
      4'd8:      pattern = 7'h00;
      4'd9:      pattern = 7'h10;
      CODE_DASH: pattern = 7'h3F;
      default:   pattern = 7'h7F;
    endcase
    return pattern;
  endfunction

  assign hi_adj = dabble_adjust(hi_bcd);
  assign lo_adj = dabble_adjust(lo_bcd);

  // 12-hour remap of the latched hour: 0 shows as 12, 13..23 fold down by 12.
  always_comb begin
    hr_map = {1'b0, lat_hr};
    if (lat_hr == 5'd0)
      hr_map = 6'd12;
    else if (lat_hr >= 5'd13)
      hr_map = {1'b0, lat_hr} - 6'd12;
  end

  // Conversion FSM: latch, select fields, six dabble iterations, then commit digits.
  always_ff @(posedge kh_clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      lat_hr        <= '0;
      lat_min       <= '0;
      lat_sec       <= '0;
      lat_show_sec  <= 1'b0;
      lat_mode_12hr <= 1'b0;
      hi_bin        <= '0;
      lo_bin        <= '0;
      hi_bcd        <= '0;
      lo_bcd        <= '0;
      iter          <= '0;
      bad           <= 1'b0;
      pm            <= 1'b0;
      digits        <= {4{CODE_BLANK}};
      colon_lit     <= 1'b0;
      pm_lit        <= 1'b0;
      busy          <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (time_valid) begin
            lat_hr        <= disp_time[23:19];
            lat_min       <= disp_time[18:13];
            lat_sec       <= disp_time[12:7];
            lat_show_sec  <= show_sec;
            lat_mode_12hr <= mode_12hr;
            busy          <= 1'b1;
            state         <= LOAD;
          end
        end
        LOAD: begin
          if (time_valid) overrun <= 1'b1;
          if (lat_show_sec)
            hi_bin <= lat_min;
          else if (lat_mode_12hr)
            hi_bin <= hr_map;
          else
            hi_bin <= {1'b0, lat_hr};
          lo_bin <= lat_show_sec ? lat_sec : lat_min;
          pm     <= (lat_hr >= 5'd12);
          bad    <= (lat_hr > 5'd23) || (lat_min > 6'd59) || (lat_sec > 6'd59);
          hi_bcd <= '0;
          lo_bcd <= '0;
          iter   <= '0;
          state  <= SHIFT;
        end
        SHIFT: begin
          if (time_valid) overrun <= 1'b1;
          hi_bcd <= {hi_adj[6:0], hi_bin[5]};
          lo_bcd <= {lo_adj[6:0], lo_bin[5]};
          hi_bin <= {hi_bin[4:0], 1'b0};
          lo_bin <= {lo_bin[4:0], 1'b0};
          iter   <= iter + 3'd1;
          if (iter == 3'd5) state <= COMMIT;
        end
        COMMIT: begin
          if (bad) begin
            digits <= {4{CODE_DASH}};
          end else begin
            if (lat_mode_12hr && !lat_show_sec && (hi_bcd[7:4] == 4'd0))
              digits[0] <= CODE_BLANK;
            else
              digits[0] <= hi_bcd[7:4];
            digits[1] <= hi_bcd[3:0];
            digits[2] <= lo_bcd[7:4];
            digits[3] <= lo_bcd[3:0];
          end
          colon_lit <= ~lat_sec[0];
          pm_lit    <= pm & lat_mode_12hr;
          // The FSM is effectively idle here, so a strobe this cycle is accepted.
          if (time_valid) begin
            lat_hr        <= disp_time[23:19];
            lat_min       <= disp_time[18:13];
            lat_sec       <= disp_time[12:7];
            lat_show_sec  <= show_sec;
            lat_mode_12hr <= mode_12hr;
            busy          <= 1'b1;
            state         <= LOAD;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Scan prescaler and digit index, free-running regardless of the FSM.
  always_ff @(posedge kh_clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      scan_idx  <= '0;
    end else if (prescaler == PRESCALE_LAST) begin
      prescaler <= '0;
      scan_idx  <= scan_idx + 2'd1;
    end else begin
      prescaler <= prescaler + 8'd1;
    end
  end

  // Registered pin drivers so anode, segments and decimal point switch together.
  always_ff @(posedge kh_clk or posedge reset) begin
    if (reset) begin
      an  <= 4'b1111;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b1000 >> scan_idx);
      seg <= seg_decode(digits[scan_idx]);
      case (scan_idx)
        2'd1:    dp <= ~colon_lit;
        2'd3:    dp <= ~pm_lit;
        default: dp <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_time_display_driver.sv
// tb_time_display_driver: directed bench for time_display_driver. Expected
// display contents are computed from the time fields and queued when a word
// is strobed, then popped and compared as the scan reaches each digit.
module tb_time_display_driver;

  localparam int SCAN_DIV = 2;

  typedef struct packed {
    logic [3:0][6:0] segs;
    logic [3:0]      dps;
  } exp_t;

  logic        kh_clk;
  logic        reset;
  logic [23:0] disp_time;
  logic        time_valid;
  logic        show_sec;
  logic        mode_12hr;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;
  logic        overrun;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  time_display_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .kh_clk     (kh_clk),
    .reset      (reset),
    .disp_time  (disp_time),
    .time_valid (time_valid),
    .show_sec   (show_sec),
    .mode_12hr  (mode_12hr),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .busy       (busy),
    .overrun    (overrun)
  );

  // 1 kHz clock, scaled to a 10-unit period.
  initial kh_clk = 1'b0;
  always #5 kh_clk = ~kh_clk;

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [6:0] seg_pattern(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic exp_t model(input int hr, input int mn, input int sc,
                                 input bit ss, input bit m12);
    exp_t e;
    int   hi;
    int   lo;
    int   d [4];
    bit   bad;
    bit   pm;
    bad = (hr > 23) || (mn > 59) || (sc > 59);
    pm  = (hr >= 12);
    if (ss) hi = mn;
    else if (m12) hi = (hr == 0) ? 12 : ((hr > 12) ? hr - 12 : hr);
    else hi = hr;
    lo = ss ? sc : mn;
    d[0] = hi / 10;
    d[1] = hi % 10;
    d[2] = lo / 10;
    d[3] = lo % 10;
    for (int i = 0; i < 4; i++) begin
      if (bad) e.segs[i] = 7'h3F;
      else if (i == 0 && m12 && !ss && d[0] == 0) e.segs[i] = 7'h7F;
      else e.segs[i] = seg_pattern(d[i]);
    end
    e.dps[0] = 1'b1;
    e.dps[1] = (sc % 2) != 0;
    e.dps[2] = 1'b1;
    e.dps[3] = !(pm && m12);
    return e;
  endfunction

  task automatic expectEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int hr, input int mn, input int sc,
                               input bit ss, input bit m12, input bit push);
    @(negedge kh_clk);
    disp_time  = {5'(hr), 6'(mn), 6'(sc), 7'h55};
    show_sec   = ss;
    mode_12hr  = m12;
    time_valid = 1'b1;
    if (push) sb.push_back(model(hr, mn, sc, ss, m12));
    @(negedge kh_clk);
    time_valid = 1'b0;
  endtask

  task automatic waitIdle(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge kh_clk);
    end
  endtask

  // Pop the next expected display and compare it digit by digit as the scan visits it.
  task automatic checkOutput(input string tag);
    exp_t       e;
    logic [3:0] target;
    int         w;
    expectEq({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge kh_clk);
      for (int i = 0; i < 4; i++) begin
        target = ~(4'b1000 >> i);
        w = 0;
        while (an !== target && w < 4 * SCAN_DIV + 4) begin
          @(negedge kh_clk);
          w++;
        end
        expectEq($sformatf("%s_an%0d", tag, i), an, target);
        expectEq($sformatf("%s_seg%0d", tag, i), seg, e.segs[i]);
        expectEq($sformatf("%s_dp%0d", tag, i), dp, e.dps[i]);
      end
    end
  endtask

  task automatic runConversion(input string tag, input int hr, input int mn, input int sc,
                               input bit ss, input bit m12);
    int cnt;
    applyStimulus(hr, mn, sc, ss, m12, 1'b1);
    expectEq({tag, "_busy_rise"}, busy, 1);
    waitIdle(cnt);
    expectEq({tag, "_busy_cycles"}, cnt, 8);
    checkOutput(tag);
  endtask

  initial begin
    int         cnt;
    int         idx;
    logic [3:0] exp_an;

    reset      = 1'b1;
    disp_time  = '0;
    time_valid = 1'b0;
    show_sec   = 1'b0;
    mode_12hr  = 1'b0;
    repeat (3) @(negedge kh_clk);

    expectEq("rst_an", an, 4'b1111);
    expectEq("rst_seg", seg, 7'h7F);
    expectEq("rst_dp", dp, 1);
    expectEq("rst_busy", busy, 0);
    expectEq("rst_overrun", overrun, 0);
    reset = 1'b0;

    $display("[TB] idle scan after reset");
    for (int k = 1; k <= 20; k++) begin
      @(negedge kh_clk);
      idx    = ((k - 1) / SCAN_DIV) % 4;
      exp_an = ~(4'b1000 >> idx);
      expectEq($sformatf("scan_an_c%0d", k), an, exp_an);
      expectEq($sformatf("scan_seg_c%0d", k), seg, 7'h7F);
      expectEq($sformatf("scan_dp_c%0d", k), dp, 1);
    end

    $display("[TB] directed conversions");
    runConversion("h24_0905", 9, 5, 42, 1'b0, 1'b0);
    runConversion("h12_0905", 9, 5, 42, 1'b0, 1'b1);
    runConversion("h12_hr0", 0, 0, 0, 1'b0, 1'b1);
    runConversion("h12_hr13", 13, 5, 42, 1'b0, 1'b1);
    runConversion("sec_5958", 3, 59, 58, 1'b1, 1'b0);
    runConversion("sec_bad61", 3, 59, 61, 1'b1, 1'b0);
    runConversion("h24_hr23", 23, 7, 31, 1'b0, 1'b0);
    runConversion("h12_hr23", 23, 7, 31, 1'b0, 1'b1);
    runConversion("h12_hr12", 12, 30, 10, 1'b0, 1'b1);
    runConversion("h24_bad_hr", 24, 10, 10, 1'b0, 1'b0);
    runConversion("h24_0000", 0, 0, 0, 1'b0, 1'b0);

    $display("[TB] overrun on strobe during conversion");
    applyStimulus(14, 27, 36, 1'b0, 1'b0, 1'b1);
    @(negedge kh_clk);
    disp_time  = {5'd2, 6'd11, 6'd22, 7'd0};
    show_sec   = 1'b0;
    mode_12hr  = 1'b0;
    time_valid = 1'b1;
    @(negedge kh_clk);
    time_valid = 1'b0;
    expectEq("ovr_pulse", overrun, 1);
    @(negedge kh_clk);
    expectEq("ovr_clear", overrun, 0);
    waitIdle(cnt);
    expectEq("ovr_busy_end", busy, 0);
    checkOutput("ovr_first_word");
    expectEq("ovr_no_second", busy, 0);
    expectEq("ovr_sb_empty", sb.size(), 0);

    $display("[TB] reset during conversion");
    applyStimulus(8, 8, 8, 1'b0, 1'b0, 1'b0);
    @(negedge kh_clk);
    @(negedge kh_clk);
    reset = 1'b1;
    @(negedge kh_clk);
    expectEq("abort_an", an, 4'b1111);
    expectEq("abort_seg", seg, 7'h7F);
    expectEq("abort_dp", dp, 1);
    expectEq("abort_busy", busy, 0);
    expectEq("abort_overrun", overrun, 0);
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge kh_clk);
      expectEq($sformatf("abort_dark_seg_c%0d", k), seg, 7'h7F);
      expectEq($sformatf("abort_dark_dp_c%0d", k), dp, 1);
    end
    runConversion("post_abort", 17, 45, 20, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
